// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EXE-side handshake bundle for the multiply/divide sequencer
interface muldiv_seq_if #(
    parameter int W = 32
);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/DIV sequencer owning HI/LO; MULDIV_FAST_MUL_EN selects a one-cycle multiply
module muldiv_seq #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       hi_q;
    logic [W-1:0]       lo_q;
    logic               done_q;
    logic               is_div;
    logic               div0;
    logic               neg_q;
    logic               neg_r;
    logic [W-1:0]       a_orig;
    // opnd holds the multiplicand or divisor magnitude; acc_lo starts as multiplier or dividend
    logic [W-1:0]       opnd;
    logic [W-1:0]       acc_hi;
    logic [W-1:0]       acc_lo;

    logic               is_sgn;
    logic [W-1:0]       a_abs;
    logic [W-1:0]       b_abs;
    logic [W:0]         mul_sum;
    logic [W:0]         div_shift;
    logic [W:0]         div_diff;
    logic [2*W-1:0]     prod_mag;
    logic [2*W-1:0]     prod_res;
    logic [W-1:0]       q_res;
    logic [W-1:0]       r_res;
    logic               accept;

    always_comb begin
        is_sgn    = ~bus.op[0];
        a_abs     = (is_sgn && bus.a[W-1]) ? -bus.a : bus.a;
        b_abs     = (is_sgn && bus.b[W-1]) ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod_mag  = {acc_hi, acc_lo};
        prod_res  = neg_q ? -prod_mag : prod_mag;
        q_res     = neg_q ? -acc_lo : acc_lo;
        r_res     = neg_r ? -acc_hi : acc_hi;
    end

    assign accept    = (state == IDLE) && bus.start && !bus.op[2] && !bus.flush;
    assign bus.stall = accept || (state == RUN) || (state == FIN);
    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] prod_fast;
    assign prod_fast = {{W{1'b0}}, opnd} * {{W{1'b0}}, acc_lo};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_orig <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= bus.op[1];
                        div0   <= bus.op[1] && (bus.b == '0);
                        neg_q  <= is_sgn && (bus.a[W-1] ^ bus.b[W-1]);
                        neg_r  <= is_sgn && bus.a[W-1];
                        a_orig <= bus.a;
                        opnd   <= bus.op[1] ? b_abs : a_abs;
                        acc_lo <= bus.op[1] ? a_abs : b_abs;
                        acc_hi <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else if (bus.start && !bus.flush && bus.op == 3'd4) begin
                        hi_q <= bus.a;
                    end else if (bus.start && !bus.flush && bus.op == 3'd5) begin
                        lo_q <= bus.a;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div) begin
                        {acc_hi, acc_lo} <= prod_fast;
                        state            <= FIN;
`endif
                    end else begin
                        if (is_div) begin
                            // restoring step: keep the trial difference only when it did not borrow
                            if (!div_diff[W]) begin
                                acc_hi <= div_diff[W-1:0];
                                acc_lo <= {acc_lo[W-2:0], 1'b1};
                            end else begin
                                acc_hi <= div_shift[W-1:0];
                                acc_lo <= {acc_lo[W-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[W:1];
                            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(W - 1)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    if (!bus.flush) begin
                        if (is_div) begin
                            if (div0) begin
                                hi_q <= a_orig;
                                lo_q <= '1;
                            end else begin
                                hi_q <= r_res;
                                lo_q <= q_res;
                            end
                        end else begin
                            {hi_q, lo_q} <= prod_res;
                        end
                        done_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - vector table plus scoreboard bench for muldiv_seq
module tb_muldiv_seq;
    localparam int W = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    muldiv_seq_if #(.W(W)) bus ();

    muldiv_seq #(.W(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] op);
`ifdef MULDIV_FAST_MUL_EN
        return (op <= 3'd1) ? 3 : W + 2;
`else
        return (op <= 3'd1) ? W + 2 : W + 2;
`endif
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int   cyc;
        int   sc;
        bit   got;
        exp_t e;
        sb.push_back('{eh, el});
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        #1;
        cyc = 0;
        sc  = 0;
        got = 0;
        while (!got && cyc < 200) begin
            if (bus.stall) sc++;
            if (bus.done) begin
                got = 1;
            end else begin
                @(negedge clk);
                bus.start = 1'b0;
                cyc++;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            check("done_timeout", 64'(cyc), 64'(lat(op)));
        end else begin
            check("hi", 64'(bus.hi), 64'(e.hi));
            check("lo", 64'(bus.lo), 64'(e.lo));
            check("latency", 64'(cyc), 64'(lat(op)));
            check("stall_cycles", 64'(sc), 64'(lat(op)));
            @(negedge clk);
            check("done_pulse_len", 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] p;
        logic [31:0] h0;
        logic [31:0] l0;
        int          seen_done;

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE});
        vecs.push_back('{3'd0, 32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1});
        vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0});
        vecs.push_back('{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0});
        vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{3'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD});
        vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3});
        vecs.push_back('{3'd3, 32'd100,       32'd7,         32'd2,         32'd14});
        vecs.push_back('{3'd3, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF});
        vecs.push_back('{3'd2, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF});
        vecs.push_back('{3'd3, 32'd5,         32'd10,        32'd5,         32'd0});
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = 64'(ra) * 64'(rb);
            vecs.push_back('{3'd1, ra, rb, p[63:32], p[31:0]});
            rb = 32'($urandom_range(1, 65535));
            vecs.push_back('{3'd3, ra, rb, ra % rb, ra / rb});
        end

        repeat (3) @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // MTHI / MTLO: written at the next edge, never stall
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAA; #1;
        check("mthi_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        check("mthi_hi", 64'(bus.hi), 64'hAA);
        bus.op = 3'd5; bus.a = 32'h55; #1;
        check("mtlo_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_lo", 64'(bus.lo), 64'h55);
        check("mtlo_hi_kept", 64'(bus.hi), 64'hAA);
        check("mt_busy", 64'(bus.busy), 64'd0);

        // flush during RUN cycle 10
        h0 = bus.hi;
        l0 = bus.lo;
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_stall", 64'(bus.stall), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen_done++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(seen_done), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'(h0));
        check("flush_lo", 64'(bus.lo), 64'(l0));

        // start held high with a different op while busy is ignored
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd5;
        @(negedge clk);
        bus.op = 3'd4; bus.a = 32'hDEAD;
        seen_done = 0;
        for (int i = 0; i < 100 && !seen_done; i++) begin
            if (bus.done) seen_done = 1;
            else @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_start_done", 64'(seen_done), 64'd1);
        check("busy_start_hi", 64'(bus.hi), 64'd0);
        check("busy_start_lo", 64'(bus.lo), 64'd15);

        // reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd77; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_hi", 64'(bus.hi), 64'd0);
        check("mid_rst_lo", 64'(bus.lo), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_stall", 64'(bus.stall), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        rst = 1'b1;

        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
